// File: rtl/pair_reduce_engine.sv
// Loads DEPTH_A samples into A, reduces adjacent pairs into B under Mode, then halts.
// Optional: define PAIR_REDUCE_SAT_EN to make the mode-0 add saturate instead of wrap.
module pair_reduce_engine #(
  parameter  int DW      = 8,
  parameter  int DEPTH_A = 8,
  localparam int AW      = $clog2(DEPTH_A)
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          Init,
  input  logic [1:0]    Mode,
  input  logic [DW-1:0] DataInA,
  input  logic          InValid,
  output logic          InReady,
  input  logic [AW-2:0] RdAddrB,
  output logic [DW-1:0] RdDataB,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [1:0] {LOAD, COMP, HALT} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] mem_a [DEPTH_A];
  logic [DW-1:0] mem_b [DEPTH_A/2];
  logic [AW-1:0] addr_a;
  logic [AW-2:0] addr_b;
  logic          rd_done, a_vld, a_odd, fin;
  logic [DW-1:0] a_q, first_q, result;
  logic [DW:0]   sum;
  logic          clr, load_wr, b_wr;

  assign clr     = Reset | Init;
  assign load_wr = (state == LOAD) && InValid && !clr;
  // a_q holds the odd element while first_q holds its even partner
  assign b_wr    = (state == COMP) && a_vld && a_odd && !clr;

  assign InReady = (state == LOAD);
  assign Busy    = (state == COMP);
  assign Done    = (state == HALT);

  always_comb begin
    sum    = {1'b0, first_q} + {1'b0, a_q};
    result = '0;
    case (Mode)
      2'd0: begin
        if (first_q <= a_q) begin
`ifdef PAIR_REDUCE_SAT_EN
          result = sum[DW] ? {DW{1'b1}} : sum[DW-1:0];
`else
          result = sum[DW-1:0];
`endif
        end else begin
          result = first_q - a_q;
        end
      end
      2'd1: result = (first_q >= a_q) ? first_q - a_q : a_q - first_q;
      2'd2: result = (first_q >= a_q) ? first_q : a_q;
      2'd3: result = (first_q <= a_q) ? first_q : a_q;
      default: result = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (load_wr && addr_a == AW'(DEPTH_A-1)) state_nx = COMP;
      COMP:    if (fin) state_nx = HALT;
      HALT:    state_nx = HALT;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) state <= LOAD;
    else     state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      addr_a  <= '0;
      addr_b  <= '0;
      a_vld   <= 1'b0;
      a_odd   <= 1'b0;
      rd_done <= 1'b0;
      fin     <= 1'b0;
    end else begin
      case (state)
        LOAD: if (load_wr) addr_a <= addr_a + 1'b1;
        COMP: begin
          a_vld <= !rd_done;
          if (!rd_done) begin
            a_q    <= mem_a[addr_a];
            a_odd  <= addr_a[0];
            addr_a <= addr_a + 1'b1;
            if (addr_a == AW'(DEPTH_A-1)) rd_done <= 1'b1;
          end
          if (a_vld && !a_odd) first_q <= a_q;
          if (b_wr) begin
            addr_b <= addr_b + 1'b1;
            if (addr_b == (AW-1)'(DEPTH_A/2-1)) fin <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memories are never cleared; only the write strobes are gated by reset/init
  always_ff @(posedge clock) begin
    if (load_wr) mem_a[addr_a] <= DataInA;
    if (b_wr)    mem_b[addr_b] <= result;
  end

  always_ff @(posedge clock) begin
    if (Reset) RdDataB <= '0;
    else       RdDataB <= mem_b[RdAddrB];
  end

endmodule
